// File: rtl/ofs_fim_pcie_pkg.sv
// Shared PCIe FIM types and constants.
// Holds the FLR request bundle and the FLR sequencer state encoding.
package ofs_fim_pcie_pkg;

  localparam int FIM_NUM_PF   = 4;
  localparam int FIM_PF_WIDTH = 2;
  localparam int FIM_VF_WIDTH = 11;

  typedef struct packed {
    logic                    is_vf;
    logic [FIM_PF_WIDTH-1:0] pf_num;
    logic [FIM_VF_WIDTH-1:0] vf_num;
  } t_flr_req;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    WAIT_ACK,
    DONE
  } t_flr_state;

  function automatic logic [FIM_PF_WIDTH-1:0] lowest_pf(
    input logic [FIM_NUM_PF-1:0] v
  );
    lowest_pf = '0;
    for (int i = FIM_NUM_PF - 1; i >= 0; i--) begin
      if (v[i]) lowest_pf = FIM_PF_WIDTH'(i);
    end
  endfunction

endpackage

// File: rtl/flr_req_fifo.sv
// Small synchronous FIFO of queued VF FLR requests.
// Push is accepted on a full FIFO when a pop happens in the same cycle.
module flr_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != FULL_CNT) | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pcie_flr_sched.sv
// FLR sequencer: one port reset per PF/VF FLR, then completion back.
// Define FLR_TIMEOUT_EN to bound the wait for afu_rst_ack.
module pcie_flr_sched
  import ofs_fim_pcie_pkg::*;
#(
  parameter int VF_QUEUE_DEPTH  = 4,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                    fim_clk,
  input  logic                    fim_rst,
  input  logic [FIM_NUM_PF-1:0]   flr_active_pf,
  input  logic                    flr_rcvd_vf,
  input  logic [FIM_PF_WIDTH-1:0] flr_rcvd_pf_num,
  input  logic [FIM_VF_WIDTH-1:0] flr_rcvd_vf_num,
  output logic                    afu_rst_req,
  output logic                    afu_rst_is_vf,
  output logic [FIM_PF_WIDTH-1:0] afu_rst_pf_num,
  output logic [FIM_VF_WIDTH-1:0] afu_rst_vf_num,
  input  logic                    afu_rst_ack,
  output logic [FIM_NUM_PF-1:0]   flr_completed_pf,
  output logic                    flr_completed_vf,
  output logic [FIM_PF_WIDTH-1:0] flr_completed_pf_num,
  output logic [FIM_VF_WIDTH-1:0] flr_completed_vf_num,
  output logic                    flr_busy,
  output logic                    flr_q_overflow,
  output logic                    flr_timeout
);

  localparam int QW = FIM_PF_WIDTH + FIM_VF_WIDTH;
  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);

  t_flr_state state_q, state_d;
  t_flr_req   tgt_q, tgt_d;

  logic [HW-1:0]           hold_q, hold_d;
  logic [FIM_NUM_PF-1:0]   act_q, pend_q, pend_d;
  logic [FIM_NUM_PF-1:0]   cpf_q, cpf_d;
  logic [FIM_NUM_PF-1:0]   rise, fall, done_mask;
  logic [FIM_PF_WIDTH-1:0] cpn_q, cpn_d;
  logic [FIM_VF_WIDTH-1:0] cvn_q, cvn_d;
  logic                    req_q, req_d;
  logic                    cvf_q, cvf_d;
  logic                    ovf_q, ovf_d;
  logic                    busy_q, busy_d;
  logic                    tmo_q, tmo_d;
  logic                    pop, full, empty, to_hit;
  logic [QW-1:0]           head;

  flr_req_fifo #(
    .DEPTH (VF_QUEUE_DEPTH),
    .W     (QW)
  ) u_fifo (
    .clk_i   (fim_clk),
    .rst_i   (fim_rst),
    .push_i  (flr_rcvd_vf),
    .pop_i   (pop),
    .din_i   ({flr_rcvd_pf_num, flr_rcvd_vf_num}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rise = flr_active_pf & ~act_q;
  assign fall = ~flr_active_pf & act_q;

`ifdef FLR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;

  always_ff @(posedge fim_clk or posedge fim_rst) begin
    if (fim_rst) to_q <= '0;
    else to_q <= (state_q == WAIT_ACK) ? to_q + 1'b1 : '0;
  end

  assign to_hit = (state_q == WAIT_ACK) &&
                  (to_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign to_hit    = 1'b0;
`endif

  always_ff @(posedge fim_clk or posedge fim_rst) begin
    if (fim_rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d = ASSERT;
        end else if (!empty) begin
          state_d = ASSERT;
          pop     = 1'b1;
        end
      end
      ASSERT:
        if (hold_q == HW'(RST_HOLD_CYCLES - 1)) state_d = WAIT_ACK;
      WAIT_ACK:
        if (afu_rst_ack || to_hit) state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d  = (state_d == ASSERT);
    hold_d = (state_q == ASSERT) ? hold_q + 1'b1 : '0;
    tgt_d  = tgt_q;
    if (state_q == IDLE && state_d == ASSERT) begin
      if (|pend_q) begin
        tgt_d.is_vf  = 1'b0;
        tgt_d.pf_num = lowest_pf(pend_q);
        tgt_d.vf_num = '0;
      end else begin
        tgt_d.is_vf  = 1'b1;
        tgt_d.pf_num = head[QW-1 -: FIM_PF_WIDTH];
        tgt_d.vf_num = head[FIM_VF_WIDTH-1:0];
      end
    end
    done_mask = '0;
    if (state_q == DONE && !tgt_q.is_vf)
      done_mask = FIM_NUM_PF'(1) << tgt_q.pf_num;
    // Abandoned PFs lose pending, so DONE sets no completion for them
    pend_d = (pend_q & ~fall & ~done_mask) | rise;
    cpf_d  = (cpf_q | (done_mask & pend_q)) & flr_active_pf;
    cvf_d  = (state_q == DONE) && tgt_q.is_vf;
    cpn_d  = cvf_d ? tgt_q.pf_num : cpn_q;
    cvn_d  = cvf_d ? tgt_q.vf_num : cvn_q;
    ovf_d  = ovf_q | (flr_rcvd_vf & full & ~pop);
    tmo_d  = tmo_q | (to_hit & ~afu_rst_ack);
    busy_d = (state_q != IDLE) | ~empty;
  end

  always_ff @(posedge fim_clk or posedge fim_rst) begin
    if (fim_rst) begin
      tgt_q  <= '0;
      hold_q <= '0;
      act_q  <= '0;
      pend_q <= '0;
      cpf_q  <= '0;
      cpn_q  <= '0;
      cvn_q  <= '0;
      req_q  <= 1'b0;
      cvf_q  <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      tgt_q  <= tgt_d;
      hold_q <= hold_d;
      act_q  <= flr_active_pf;
      pend_q <= pend_d;
      cpf_q  <= cpf_d;
      cpn_q  <= cpn_d;
      cvn_q  <= cvn_d;
      req_q  <= req_d;
      cvf_q  <= cvf_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      tmo_q  <= tmo_d;
    end
  end

  assign afu_rst_req          = req_q;
  assign afu_rst_is_vf        = tgt_q.is_vf;
  assign afu_rst_pf_num       = tgt_q.pf_num;
  assign afu_rst_vf_num       = tgt_q.vf_num;
  assign flr_completed_pf     = cpf_q;
  assign flr_completed_vf     = cvf_q;
  assign flr_completed_pf_num = cpn_q;
  assign flr_completed_vf_num = cvn_q;
  assign flr_busy             = busy_q;
  assign flr_q_overflow       = ovf_q;
  assign flr_timeout          = tmo_q;

endmodule

// File: tb/tb_pcie_flr_sched.sv
// Directed self-checking bench for pcie_flr_sched.
// Hold = 4 cycles, timeout = 64 cycles, queue depth = 4.
module tb_pcie_flr_sched;
  import ofs_fim_pcie_pkg::*;

  logic                    fim_clk = 1'b0;
  logic                    fim_rst = 1'b1;
  logic [FIM_NUM_PF-1:0]   flr_active_pf;
  logic                    flr_rcvd_vf;
  logic [FIM_PF_WIDTH-1:0] flr_rcvd_pf_num;
  logic [FIM_VF_WIDTH-1:0] flr_rcvd_vf_num;
  logic                    afu_rst_req;
  logic                    afu_rst_is_vf;
  logic [FIM_PF_WIDTH-1:0] afu_rst_pf_num;
  logic [FIM_VF_WIDTH-1:0] afu_rst_vf_num;
  logic                    afu_rst_ack;
  logic [FIM_NUM_PF-1:0]   flr_completed_pf;
  logic                    flr_completed_vf;
  logic [FIM_PF_WIDTH-1:0] flr_completed_pf_num;
  logic [FIM_VF_WIDTH-1:0] flr_completed_vf_num;
  logic                    flr_busy;
  logic                    flr_q_overflow;
  logic                    flr_timeout;

  int   n_chk    = 0;
  int   n_fail   = 0;
  int   n_vfdone = 0;
  int   n_req    = 0;
  logic req_prev = 1'b0;

  pcie_flr_sched #(
    .VF_QUEUE_DEPTH  (4),
    .RST_HOLD_CYCLES (4),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .fim_clk              (fim_clk),
    .fim_rst              (fim_rst),
    .flr_active_pf        (flr_active_pf),
    .flr_rcvd_vf          (flr_rcvd_vf),
    .flr_rcvd_pf_num      (flr_rcvd_pf_num),
    .flr_rcvd_vf_num      (flr_rcvd_vf_num),
    .afu_rst_req          (afu_rst_req),
    .afu_rst_is_vf        (afu_rst_is_vf),
    .afu_rst_pf_num       (afu_rst_pf_num),
    .afu_rst_vf_num       (afu_rst_vf_num),
    .afu_rst_ack          (afu_rst_ack),
    .flr_completed_pf     (flr_completed_pf),
    .flr_completed_vf     (flr_completed_vf),
    .flr_completed_pf_num (flr_completed_pf_num),
    .flr_completed_vf_num (flr_completed_vf_num),
    .flr_busy             (flr_busy),
    .flr_q_overflow       (flr_q_overflow),
    .flr_timeout          (flr_timeout)
  );

  always #5 fim_clk = ~fim_clk;

  always @(negedge fim_clk) begin
    if (flr_completed_vf) n_vfdone++;
    if (afu_rst_req && !req_prev) n_req++;
    req_prev = afu_rst_req;
  end

  task automatic chk_eq(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge fim_clk);
    #1;
  endtask

  task automatic vf_strobe(input int pf, input int vf);
    flr_rcvd_vf     = 1'b1;
    flr_rcvd_pf_num = FIM_PF_WIDTH'(pf);
    flr_rcvd_vf_num = FIM_VF_WIDTH'(vf);
    tick();
    flr_rcvd_vf     = 1'b0;
  endtask

  task automatic serve(input logic is_vf, input int pf,
                       input int vf, input string tag);
    int n;
    n = 0;
    while (!afu_rst_req && n < 50) begin tick(); n++; end
    chk_eq({tag, "_req"}, 32'(afu_rst_req), 1);
    chk_eq({tag, "_isvf"}, 32'(afu_rst_is_vf), 32'(is_vf));
    chk_eq({tag, "_pf"}, 32'(afu_rst_pf_num), pf);
    if (is_vf) chk_eq({tag, "_vf"}, 32'(afu_rst_vf_num), vf);
    n = 0;
    while (afu_rst_req && n < 50) begin tick(); n++; end
    afu_rst_ack = 1'b1;
    tick();
    afu_rst_ack = 1'b0;
    tick();
    if (is_vf) begin
      chk_eq({tag, "_cvf"}, 32'(flr_completed_vf), 1);
      chk_eq({tag, "_cpn"}, 32'(flr_completed_pf_num), pf);
      chk_eq({tag, "_cvn"}, 32'(flr_completed_vf_num), vf);
    end else begin
      chk_eq({tag, "_cpf"}, 32'(flr_completed_pf[pf]), 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, r0;
    flr_active_pf   = '0;
    flr_rcvd_vf     = 1'b0;
    flr_rcvd_pf_num = '0;
    flr_rcvd_vf_num = '0;
    afu_rst_ack     = 1'b0;
    repeat (3) tick();
    chk_eq("rst_req", 32'(afu_rst_req), 0);
    chk_eq("rst_busy", 32'(flr_busy), 0);
    chk_eq("rst_ovf", 32'(flr_q_overflow), 0);
    chk_eq("rst_tmo", 32'(flr_timeout), 0);
    chk_eq("rst_cpf", 32'(flr_completed_pf), 0);
    chk_eq("rst_cvf", 32'(flr_completed_vf), 0);
    fim_rst = 1'b0;
    tick();

    // Single VF request: latency, hold width, completion strobe
    vf_strobe(0, 3);
    chk_eq("vf_lat1", 32'(afu_rst_req), 0);
    tick();
    chk_eq("vf_lat2", 32'(afu_rst_req), 1);
    chk_eq("vf_isvf", 32'(afu_rst_is_vf), 1);
    chk_eq("vf_pf", 32'(afu_rst_pf_num), 0);
    chk_eq("vf_vf", 32'(afu_rst_vf_num), 3);
    n = 0;
    while (afu_rst_req && n < 20) begin n++; tick(); end
    chk_eq("vf_hold", n, 4);
    repeat (5) tick();
    afu_rst_ack = 1'b1;
    tick();
    afu_rst_ack = 1'b0;
    chk_eq("vf_early", 32'(flr_completed_vf), 0);
    tick();
    chk_eq("vf_cvf", 32'(flr_completed_vf), 1);
    chk_eq("vf_cpn", 32'(flr_completed_pf_num), 0);
    chk_eq("vf_cvn", 32'(flr_completed_vf_num), 3);
    tick();
    chk_eq("vf_single", 32'(flr_completed_vf), 0);

    // PF request and level release
    flr_active_pf = 4'b0001;
    tick();
    chk_eq("pf_lat1", 32'(afu_rst_req), 0);
    tick();
    chk_eq("pf_lat2", 32'(afu_rst_req), 1);
    serve(1'b0, 0, 0, "pf");
    repeat (3) tick();
    chk_eq("pf_held", 32'(flr_completed_pf), 1);
    flr_active_pf = 4'b0000;
    tick();
    chk_eq("pf_release", 32'(flr_completed_pf), 0);

    // PF and VF in the same cycle: PF first
    flr_active_pf   = 4'b0001;
    flr_rcvd_vf     = 1'b1;
    flr_rcvd_pf_num = '0;
    flr_rcvd_vf_num = 11'd1;
    tick();
    flr_rcvd_vf = 1'b0;
    serve(1'b0, 0, 0, "pri_pf");
    serve(1'b1, 0, 1, "pri_vf");
    flr_active_pf = 4'b0000;
    repeat (2) tick();

    // Duplicate VF requests are each serviced
    d0 = n_vfdone;
    vf_strobe(1, 2);
    vf_strobe(1, 2);
    serve(1'b1, 1, 2, "dup_a");
    serve(1'b1, 1, 2, "dup_b");
    repeat (10) tick();
    chk_eq("dup_cnt", n_vfdone - d0, 2);

    // Six strobes: one in service, four queued, one dropped
    for (int i = 0; i < 6; i++) vf_strobe(2, 10 + i);
    chk_eq("ovf_wait", 32'(afu_rst_req), 0);
    chk_eq("ovf_tgt", 32'(afu_rst_vf_num), 10);
    chk_eq("ovf_flag", 32'(flr_q_overflow), 1);
    afu_rst_ack = 1'b1;
    tick();
    afu_rst_ack = 1'b0;
    tick();
    chk_eq("ovf_first", 32'(flr_completed_vf_num), 10);
    for (int k = 11; k < 15; k++) serve(1'b1, 2, k, "ovf_q");
    r0 = n_req;
    repeat (20) tick();
    chk_eq("ovf_drop", n_req - r0, 0);
    chk_eq("ovf_busy", 32'(flr_busy), 0);
    chk_eq("ovf_sticky", 32'(flr_q_overflow), 1);

    // No ack: timeout or indefinite wait
    vf_strobe(0, 7);
    n = 0;
    while (!afu_rst_req && n < 20) begin tick(); n++; end
    n = 0;
    while (afu_rst_req && n < 20) begin tick(); n++; end
`ifdef FLR_TIMEOUT_EN
    n = 0;
    while (!flr_timeout && n < 200) begin tick(); n++; end
    chk_eq("tmo_cycles", n, 64);
    chk_eq("tmo_early", 32'(flr_completed_vf), 0);
    tick();
    chk_eq("tmo_cvf", 32'(flr_completed_vf), 1);
    chk_eq("tmo_cvn", 32'(flr_completed_vf_num), 7);
`else
    d0 = n_vfdone;
    repeat (1000) tick();
    chk_eq("wait_req", 32'(afu_rst_req), 0);
    chk_eq("wait_busy", 32'(flr_busy), 1);
    chk_eq("wait_tmo", 32'(flr_timeout), 0);
    chk_eq("wait_nodone", n_vfdone - d0, 0);
    afu_rst_ack = 1'b1;
    tick();
    afu_rst_ack = 1'b0;
    tick();
    chk_eq("wait_cvf", 32'(flr_completed_vf), 1);
    chk_eq("wait_cvn", 32'(flr_completed_vf_num), 7);
`endif
    repeat (3) tick();

    // Reset in the middle of ASSERT with one entry queued
    vf_strobe(1, 5);
    tick();
    flr_rcvd_vf     = 1'b1;
    flr_rcvd_vf_num = 11'd6;
    tick();
    flr_rcvd_vf = 1'b0;
    chk_eq("mid_req", 32'(afu_rst_req), 1);
    d0 = n_vfdone;
    r0 = n_req;
    fim_rst = 1'b1;
    #1;
    chk_eq("mid_rst_req", 32'(afu_rst_req), 0);
    chk_eq("mid_rst_isvf", 32'(afu_rst_is_vf), 0);
    chk_eq("mid_rst_pf", 32'(afu_rst_pf_num), 0);
    chk_eq("mid_rst_vf", 32'(afu_rst_vf_num), 0);
    chk_eq("mid_rst_busy", 32'(flr_busy), 0);
    chk_eq("mid_rst_ovf", 32'(flr_q_overflow), 0);
    chk_eq("mid_rst_tmo", 32'(flr_timeout), 0);
    repeat (2) tick();
    fim_rst = 1'b0;
    repeat (20) tick();
    chk_eq("mid_noreq", n_req - r0, 0);
    chk_eq("mid_nodone", n_vfdone - d0, 0);
    chk_eq("mid_busy", 32'(flr_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_flr_sched.md
# pcie_flr_sched

FLR sequencer in the fim_clk domain. It sits between the FLR CDC resync stage and the AFU/port reset logic. It takes PF FLR levels and VF FLR request pulses, which are already synchronized into fim_clk, and queues the VF requests. For each FLR it issues one port-reset request, waits for the AFU to report that reset is done, and then returns the PF completion level or the VF completion pulse to the PCIe sideband.

## Interface
Parameters:
- VF_QUEUE_DEPTH, 4, VF request FIFO entries (power of 2, ≥2)
- RST_HOLD_CYCLES, 16, cycles afu_rst_req is held high (≥1)
- TIMEOUT_CYCLES, 4096, maximum cycles spent waiting for afu_rst_ack (only with FLR_TIMEOUT_EN)

Ports:
- fim_clk  in  1  FIM clock; one clock domain only
- fim_rst  in  1  reset; asynchronous, active-high
- flr_active_pf  in  FIM_NUM_PF  PF FLR active level, one bit per PF
- flr_rcvd_vf  in  1  one-cycle VF FLR request strobe
- flr_rcvd_pf_num  in  FIM_PF_WIDTH  PF number, qualified by flr_rcvd_vf
- flr_rcvd_vf_num  in  FIM_VF_WIDTH  VF number, qualified by flr_rcvd_vf
- afu_rst_req  out  1  port reset request
- afu_rst_is_vf  out  1  target type: 1 = VF, 0 = PF
- afu_rst_pf_num  out  FIM_PF_WIDTH  target PF
- afu_rst_vf_num  out  FIM_VF_WIDTH  target VF
- afu_rst_ack  in  1  one-cycle strobe: reset done, target quiesced
- flr_completed_pf  out  FIM_NUM_PF  PF FLR completion level
- flr_completed_vf  out  1  one-cycle VF completion strobe
- flr_completed_pf_num  out  FIM_PF_WIDTH  PF number of the completed VF FLR
- flr_completed_vf_num  out  FIM_VF_WIDTH  VF number of the completed VF FLR
- flr_busy  out  1  FSM is not in IDLE, or the queue is not empty
- flr_q_overflow  out  1  sticky; a VF request was dropped because the queue was full
- flr_timeout  out  1  sticky; an ack wait timed out

## Operation
Reset values:
- All outputs are 0.
- The FIFO is empty.
- The FSM is in IDLE.
- The pf_pending and pf_done vectors are cleared.

PF request tracking:
- A rising edge on flr_active_pf[i] sets pf_pending[i].

VF request queueing:
- Each flr_rcvd_vf strobe pushes {pf_num, vf_num} into the FIFO.
- If the FIFO is full, the request is dropped and flr_q_overflow is set. The flag is cleared only by reset.

FSM states:
- IDLE:
  - If pf_pending is nonzero, select the lowest set index and go to ASSERT with is_vf = 0.
  - Otherwise, if the FIFO is not empty, pop the head and go to ASSERT with is_vf = 1.
  - PF requests always take priority over VF requests.
- ASSERT:
  - afu_rst_req = 1 and the target outputs are stable.
  - Stay for exactly RST_HOLD_CYCLES cycles, then go to WAIT_ACK.
- WAIT_ACK:
  - afu_rst_req = 0; the target outputs are held.
  - On afu_rst_ack, go to DONE.
  - An afu_rst_ack received in any other state is ignored.
- DONE (one cycle):
  - PF target: clear pf_pending[i] and set flr_completed_pf[i].
  - VF target: drive a one-cycle flr_completed_vf strobe with the target numbers.
  - Go to IDLE.

PF completion release:
- flr_completed_pf[i] stays high until flr_active_pf[i] falls, then clears on the next cycle.
- If flr_active_pf[i] falls while pf_pending[i] is set (the FLR is abandoned), clear pf_pending[i]. Any reset already in progress for that PF still completes, but flr_completed_pf[i] is not set.

Boundary conditions:
- Push and pop in the same cycle on a full FIFO: the push is accepted.
- Duplicate VF requests are each serviced separately.
- fim_rst asserted mid-sequence: every state returns to its reset value immediately, with no completion reported.

## Timing
- flr_rcvd_vf at cycle 0: the FIFO write lands at cycle 1 and afu_rst_req rises at cycle 2 (when the FSM is idle and no PF is pending).
- flr_active_pf rising at cycle 0: the edge is registered at cycle 1 and afu_rst_req rises at cycle 2.
- afu_rst_ack at cycle N: the completion output (strobe or level) is driven at cycle N+2.
- Back-to-back requests: the next afu_rst_req can rise at the earliest 2 cycles after the previous DONE.
- All outputs are registered.

## Configuration
FLR_TIMEOUT_EN:
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits runs in WAIT_ACK.
  - When it reaches TIMEOUT_CYCLES, flr_timeout is set and the FSM goes to DONE, reporting completion as if ack had arrived.
- Undefined:
  - There is no counter; WAIT_ACK waits indefinitely.
  - flr_timeout is tied to 0.

## Structure
- ofs_fim_pcie_pkg holds:
  - t_flr_req {is_vf, pf_num, vf_num}
  - t_flr_state enum {IDLE, ASSERT, WAIT_ACK, DONE}
- The existing FIM_NUM_PF, FIM_PF_WIDTH and FIM_VF_WIDTH constants are used unchanged.
- One sub-module, flr_req_fifo: a synchronous FIFO of depth VF_QUEUE_DEPTH with registered output, full and empty flags.

## Test plan
Benches use RST_HOLD_CYCLES = 4 and TIMEOUT_CYCLES = 64.
- VF request: flr_rcvd_vf with pf 0, vf 3; afu_rst_ack 5 cycles after afu_rst_req falls -> afu_rst_req high for 4 cycles with is_vf = 1 and vf_num = 3, then a single flr_completed_vf strobe with {0, 3}.
- PF request: flr_active_pf = 1 rises, ack is returned -> flr_completed_pf[0] = 1 and stays high until flr_active_pf[0] falls, then returns to 0 one cycle later.
- Priority: flr_rcvd_vf (vf 1) and a rising flr_active_pf[0] in the same cycle -> the PF is serviced first, then VF 1.
- Overflow: 6 VF strobes on consecutive cycles with depth 4 while busy -> 5 requests are serviced (1 in service plus 4 queued), 1 is dropped, and flr_q_overflow = 1.
- Timeout (FLR_TIMEOUT_EN defined): no ack -> flr_timeout = 1 after 64 WAIT_ACK cycles, followed by the completion strobe. Without the macro: the FSM stays in WAIT_ACK for ≥1000 cycles.
- Reset mid-ASSERT: fim_rst pulses -> all outputs are 0 immediately, the FIFO is empty, and no completion is reported.
